// File: rtl/ripple_count_monitor_pkg.sv
// Shared types and constants for the ripple counter and its monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ripple_pkg;

  // Default width of the ripple-carry counter and everything that watches it.
  localparam int RIPPLE_WIDTH = 4;

  // Monitor sequence-tracking states.
  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    RUN       = 2'd1,
    ERR       = 2'd2
  } rcm_state_t;

endpackage

// File: rtl/ripple_count_monitor_sync_stable_filter.sv
// Two-flop resynchroniser plus stability filter for an asynchronous, glitchy bus.
// Latency: accept strobe is high in the cycle before the edge E0+STABLE_N+1 (E0 = first sampling edge).
// Backpressure: none; strobes once per distinct stable value, downstream must absorb it.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   q_in   [WIDTH]      - raw asynchronous input
//   acc                 - one-cycle strobe: acc_val is a newly settled value
//   acc_val[WIDTH]      - settled value, valid while acc is high
module sync_stable_filter
  import ripple_pkg::*;
#(
  parameter int WIDTH    = RIPPLE_WIDTH,
  parameter int STABLE_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  output logic             acc,
  output logic [WIDTH-1:0] acc_val
);

  localparam int            HW   = $clog2(STABLE_N + 1);
  localparam logic [HW-1:0] HSAT = HW'(STABLE_N);
  localparam logic [HW-1:0] HONE = HW'(1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] qs;
  logic [WIDTH-1:0] cand;
  logic [HW-1:0]    hcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      qs   <= '0;
      cand <= '0;
      hcnt <= '0;
    end else begin
      s1 <= q_in;
      qs <= s1;
      if (qs != cand) begin
        cand <= qs;
        hcnt <= HONE;
      end else if (hcnt != HSAT) begin
        hcnt <= hcnt + HONE;
      end
    end
  end

  // The strobe marks the edge on which hcnt will land on STABLE_N. A new
  // candidate only qualifies immediately when a single sample is enough;
  // once saturated the count never re-reaches the threshold, so each
  // stable value strobes exactly once.
  assign acc     = (qs != cand) ? (HONE == HSAT) : (hcnt == HSAT - HONE);
  assign acc_val = qs;

endmodule

// File: rtl/ripple_count_monitor.sv
// Resynchronises a ripple counter, checks its +1 sequence, counts wraps and forwards settled values.
// Latency: out_data/out_valid update on edge E0+STABLE_N+1 after q_in settles at sampling edge E0.
// Backpressure: single holding register; an unconsumed value is overwritten by the newest and overrun latches.
//
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   q_in      [WIDTH]             - ripple counter output (asynchronous)
//   out_data  [WIDTH], out_valid  - last accepted value / unconsumed flag
//   out_ready                     - consumer takes out_data when out_valid && out_ready
//   wrap_cnt  [WRAP_W]            - max->0 transitions, modulo 2^WRAP_W
//   cnt_reset                     - one-cycle pulse: 0 accepted from a value other than max
//   seq_err, overrun              - sticky error flags
module ripple_count_monitor
  import ripple_pkg::*;
#(
  parameter int WIDTH    = RIPPLE_WIDTH,
  parameter int STABLE_N = 2,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  q_in,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              cnt_reset,
  output logic              seq_err,
  output logic              overrun
);

  localparam logic [WIDTH-1:0] VMAX = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  rcm_state_t       state;
  rcm_state_t       state_nx;
  logic [WIDTH-1:0] last;
  logic             acc;
  logic [WIDTH-1:0] acc_val;
  logic             wrap_inc;
  logic             crst;
  logic             err_set;

  sync_stable_filter #(
    .WIDTH    (WIDTH),
    .STABLE_N (STABLE_N)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .q_in    (q_in),
    .acc     (acc),
    .acc_val (acc_val)
  );

  // Classify each accepted value against the previous one.
  always_comb begin
    state_nx = state;
    wrap_inc = 1'b0;
    crst     = 1'b0;
    err_set  = 1'b0;
    if (acc) begin
      case (state)
        SYNC_WAIT: begin
          // First value after reset is only a baseline.
          state_nx = RUN;
        end
        RUN: begin
          if (last == VMAX && acc_val == '0) begin
            wrap_inc = 1'b1;
          end else if (last != VMAX && acc_val == last + ONE) begin
            // normal increment, nothing to flag
          end else if (acc_val == '0) begin
            crst = 1'b1;
          end else begin
            err_set  = 1'b1;
            state_nx = ERR;
          end
        end
        ERR: begin
          // Only a counter reset re-establishes a trusted sequence.
          if (acc_val == '0) begin
            crst     = 1'b1;
            state_nx = RUN;
          end
        end
        default: state_nx = SYNC_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SYNC_WAIT;
      last      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      wrap_cnt  <= '0;
      cnt_reset <= 1'b0;
      seq_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt_reset <= crst;
      if (wrap_inc) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
      if (err_set) begin
        seq_err <= 1'b1;
      end
      if (acc) begin
        last      <= acc_val;
        out_data  <= acc_val;
        out_valid <= 1'b1;
        // Simultaneous consume frees the slot, so only a stalled slot overruns.
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
